// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse button front-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package morse_pkg;

    // Per-channel button state.
    typedef enum logic [1:0] {
        UP   = 2'd0,
        DOWN = 2'd1,
        HELD = 2'd2
    } btn_state_t;

    // Default timing at a 25 MHz system clock.
    localparam int CLK_HZ                  = 25_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;  // 10 ms
    localparam int HOLD_CYCLES_DEFAULT     = CLK_HZ / 2;    // 0.5 s

    // Number of bits needed to count 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (longint p = 1; p < longint'(value); p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debouncer, UP/DOWN/HELD FSM, hold and repeat timers.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from a stable raw edge to level/press/release.
// Backpressure: none; all outputs are registered strobes/levels, no handshake.
// Ports: raw_in (async pin), repeat_en/repeat_interval (sync config) in;
//        level, press/release/hold/repeat pulses and held out.
module button_channel
    import morse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             internal_rst_n,
    input  logic             raw_in,
    input  logic             repeat_en,
    input  logic [CNT_W-1:0] repeat_interval,
    output logic             level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             hold_pulse,
    output logic             repeat_pulse,
    output logic             held
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       rcnt_q, rcnt_d;
    btn_state_t             state_q, state_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   hold_q, hold_d;
    logic                   rpt_q, rpt_d;
    logic                   held_q, held_d;

    logic                   s;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       rep_tc;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        s       = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;

        // Any sample agreeing with level restarts the stability count.
        if (s == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_TC) begin
            dcnt_d  = '0;
            level_d = s;
            rise    = s;
            fall    = ~s;
        end else begin
            dcnt_d = dcnt_q + CNT_ONE;
        end

        // An interval of 0 behaves as 1.
        rep_tc = (repeat_interval == '0) ? '0 : repeat_interval - CNT_ONE;

        state_d = state_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        hold_d  = 1'b0;
        rpt_d   = 1'b0;

        // A debounced fall is checked first so it masks hold/repeat terminal counts.
        case (state_q)
            UP: begin
                if (rise) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end
            end
            DOWN: begin
                if (fall) begin
                    state_d = UP;
                    rel_d   = 1'b1;
                    hcnt_d  = '0;
                    rcnt_d  = '0;
                end else if (hcnt_q == HOLD_TC) begin
                    state_d = HELD;
                    hold_d  = 1'b1;
                    rpt_d   = repeat_en;
                    rcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = UP;
                    rel_d   = 1'b1;
                    hcnt_d  = '0;
                    rcnt_d  = '0;
                end else if (!repeat_en) begin
                    rcnt_d = '0;
                end else if (rcnt_q >= rep_tc) begin
                    // >= lets a shortened interval fire on the next cycle instead of wrapping.
                    rpt_d  = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = UP;
            end
        endcase

        held_d = (state_d == HELD);
    end

    always_ff @(posedge clk or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= UP;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            hold_q  <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
            held_q  <= held_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign hold_pulse    = hold_q;
    assign repeat_pulse  = rpt_q;
    assign held          = held_q;

endmodule

// File: rtl/button_conditioner_array.sv
// N-channel push-button conditioner: fans inputs out to independent button_channel instances.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles raw edge to level/press/release; all outputs registered.
// Backpressure: none; events are single-cycle strobes with no handshake.
// Ports: raw_in/repeat_en per channel, shared repeat_interval in; per-channel level, pulses, held out.
module button_conditioner_array
    import morse_pkg::*;
#(
    parameter int N_CH            = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int HOLD_CYCLES     = 12_500_000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             internal_rst_n,
    input  logic [N_CH-1:0]  raw_in,
    input  logic [N_CH-1:0]  repeat_en,
    input  logic [CNT_W-1:0] repeat_interval,
    output logic [N_CH-1:0]  level,
    output logic [N_CH-1:0]  press_pulse,
    output logic [N_CH-1:0]  release_pulse,
    output logic [N_CH-1:0]  hold_pulse,
    output logic [N_CH-1:0]  repeat_pulse,
    output logic [N_CH-1:0]  held
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 2");
    end
    if (CNT_W < clog2(HOLD_CYCLES) || CNT_W < clog2(DEBOUNCE_CYCLES)) begin : g_bad_cnt
        $error("CNT_W too narrow for the configured timing");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk            (clk),
            .internal_rst_n (internal_rst_n),
            .raw_in         (raw_in[i]),
            .repeat_en      (repeat_en[i]),
            .repeat_interval(repeat_interval),
            .level          (level[i]),
            .press_pulse    (press_pulse[i]),
            .release_pulse  (release_pulse[i]),
            .hold_pulse     (hold_pulse[i]),
            .repeat_pulse   (repeat_pulse[i]),
            .held           (held[i])
        );
    end

endmodule
